pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Detects RAW data hazards between the instruction in ID and older in-flight writers, and inserts bubbles.
- Flushes the three younger stages when a branch or jump resolves taken in MEM.
- Drains the pipeline on an external hold request and acknowledges once it is empty.
- Sits beside the stage registers and drives their write-enable and flush controls; it keeps saturating stall and flush counters for profiling.

Parameters:
FORWARDING, 1, 1 = EX/MEM forwarding exists, so only load-use stalls; 0 = stall on any in-flight writer (EX, MEM or WB).
DRAIN_CYCLES, 3, number of cycles spent in DRAIN before HELD.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes rd
ex_rd  in  5  EX destination register
mem_regwrite  in  1  MEM instruction writes rd
mem_rd  in  5  MEM destination register
wb_regwrite  in  1  WB instruction writes rd
wb_rd  in  5  WB destination register
mem_pcsrc  in  1  branch/jump resolved taken in MEM this cycle
hold_req  in  1  external request to freeze and drain the pipeline (level)
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID to NOP
idex_flush  out  1  load a bubble into ID/EX
exmem_flush  out  1  load a bubble into EX/MEM
hold_ack  out  1  pipeline is drained and frozen
ctrl_state  out  2  0=RUN, 1=STALL, 2=DRAIN, 3=HELD
stall_cnt  out  CNT_W  cycles stalled by data hazards
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst=0, asynchronous): state=RUN; drain counter=0; stall_cnt=0; flush_cnt=0.
- Outputs forced while rst=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1, hold_ack=0.
- Hazard term: hz(rd,we) = we & (rd!=0) & ((id_use_rs1 & rd==id_rs1) | (id_use_rs2 & rd==id_rs2)).
- Data hazard, FORWARDING=1: data_hz = ex_memread & hz(ex_rd,1).
- Data hazard, FORWARDING=0: data_hz = hz(ex_rd,ex_regwrite) | hz(mem_rd,mem_regwrite) | hz(wb_rd,wb_regwrite). WB is included because the register file is read-before-write.
- Flush, stall and hold outputs are combinational from the current state and inputs; state and counters are registered.
- Default (no action): pc_write=1, ifid_write=1, all flushes=0, hold_ack=0.
- Priority: mem_pcsrc > hold_req > data_hz.
- RUN/STALL, mem_pcsrc=1: pc_write=1, ifid_write=1, ifid_flush=idex_flush=exmem_flush=1; flush_cnt++; next=RUN. data_hz is ignored because the ID instruction is squashed.
- RUN/STALL, hold_req=1 (no mem_pcsrc): pc_write=0, ifid_write=0, idex_flush=1; drain counter=0; next=DRAIN.
- RUN/STALL, data_hz=1 (no pcsrc, no hold): pc_write=0, ifid_write=0, idex_flush=1; stall_cnt++; next=STALL.
- RUN/STALL, otherwise: default outputs; next=RUN.
- DRAIN: pc_write=0, ifid_write=0, idex_flush=1; counter++; when the counter reaches DRAIN_CYCLES-1, next=HELD.
- DRAIN, mem_pcsrc=1: PC redirect is allowed (pc_write=1, ifid_write=1, all three flushes=1); flush_cnt++; counter restarts at 0; stay in DRAIN.
- DRAIN, hold_req=0: next=RUN, with default outputs that cycle unless mem_pcsrc is also high.
- HELD: hold_ack=1, pc_write=0, ifid_write=0, idex_flush=1.
- HELD, hold_req=0: next=RUN; hold_ack deasserts in the first RUN cycle.
- HELD, mem_pcsrc: cannot occur (MEM is empty); it is ignored.
- hold_ack timing: hold_req first sampled high in RUN at cycle t → DRAIN at t+1..t+DRAIN_CYCLES → HELD with hold_ack=1 from t+DRAIN_CYCLES+1.
- Counters saturate at all-ones; they never wrap.
- rd=x0 never causes a hazard.
- rst asserted mid-DRAIN or mid-HELD returns the block to RUN immediately and drops hold_ack.

Test Plan:
- FORWARDING=1, ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle → pc_write=0, ifid_write=0, idex_flush=1, ctrl_state=1 next cycle, stall_cnt=1; ex_rd=0 with the same setup → no stall.
- FORWARDING=0, mem_regwrite=1, mem_rd=7, id_rs2=7, id_use_rs2=1 → stall. Same with id_use_rs2=0 → no stall.
- mem_pcsrc=1 together with data_hz=1 → all three flushes=1, pc_write=1, flush_cnt=1, stall_cnt unchanged, next state RUN.
- hold_req raised at cycle 10 (DRAIN_CYCLES=3) → ctrl_state=2 for cycles 11-13, hold_ack=1 from cycle 14. hold_req dropped at cycle 20 → RUN and hold_ack=0 at cycle 21.
- mem_pcsrc pulse at the second DRAIN cycle → redirect and flushes that cycle, counter restarts, hold_ack delayed by 2 cycles; flush_cnt increments.
- Force 2^16+5 stall cycles with CNT_W=16 → stall_cnt=16'hFFFF. rst low mid-HELD → hold_ack=0, ctrl_state=0, counters=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, flush and hold sequencing controller for a 5-stage pipeline
module pipeline_hazard_ctrl #(
   parameter int FORWARDING   = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [4:0]       ex_rd,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_rd,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_rd,
   input  logic             mem_pcsrc,
   input  logic             hold_req,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             hold_ack,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HELD  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_inc, flush_inc;
   logic             hz_ld, hz_ex, hz_mem, hz_wb, data_hz;

   // A writer to x0 never creates a dependency.
   function automatic logic hz(input logic [4:0] rd, input logic we,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2);
      return we & (rd != 5'd0) & ((use1 & (rd == rs1)) | (use2 & (rd == rs2)));
   endfunction

   assign hz_ld  = hz(ex_rd,  1'b1,         id_rs1, id_rs2, id_use_rs1, id_use_rs2);
   assign hz_ex  = hz(ex_rd,  ex_regwrite,  id_rs1, id_rs2, id_use_rs1, id_use_rs2);
   assign hz_mem = hz(mem_rd, mem_regwrite, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
   assign hz_wb  = hz(wb_rd,  wb_regwrite,  id_rs1, id_rs2, id_use_rs1, id_use_rs2);

   // With forwarding only a load in EX forces a bubble; without it any in-flight writer does,
   // WB included because the register file is read before it is written.
   assign data_hz = (FORWARDING != 0) ? (ex_memread & hz_ld) : (hz_ex | hz_mem | hz_wb);

   // Next-state, counter updates and stage controls; reset forces a frozen, flushed pipeline.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      hold_ack    = 1'b0;
      case (state_q)
         ST_DRAIN: begin
            if (!hold_req) begin
               state_d = ST_RUN;
               if (mem_pcsrc) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
               end
            end else if (mem_pcsrc) begin
               // Redirect is allowed mid-drain; the younger stages refill so draining restarts.
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_inc   = 1'b1;
               drain_cnt_d = '0;
            end else begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               if (drain_cnt_q == DRAIN_LAST) begin
                  state_d = ST_HELD;
               end else begin
                  drain_cnt_d = drain_cnt_q + DCW'(1);
               end
            end
         end
         ST_HELD: begin
            // MEM is empty here, so mem_pcsrc cannot be legitimately raised and is ignored.
            hold_ack   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (!hold_req) state_d = ST_RUN;
         end
         default: begin
            if (mem_pcsrc) begin
               // The ID instruction is squashed, so any data hazard it had is irrelevant.
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_inc   = 1'b1;
               state_d     = ST_RUN;
            end else if (hold_req) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_flush  = 1'b1;
               drain_cnt_d = '0;
               state_d     = ST_DRAIN;
            end else if (data_hz) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               stall_inc  = 1'b1;
               state_d    = ST_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase

      stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

      if (!rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         hold_ack    = 1'b0;
      end
   end

   // State and saturating profiling counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ctrl_state = state_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic        id_use_rs1, id_use_rs2, ex_memread, ex_regwrite;
   logic        mem_regwrite, wb_regwrite, mem_pcsrc, hold_req;

   logic        f_pcw, f_ifw, f_iff, f_idf, f_exf, f_ack;
   logic [1:0]  f_st;
   logic [15:0] f_stall, f_flush;
   logic        n_pcw, n_ifw, n_iff, n_idf, n_exf, n_ack;
   logic [1:0]  n_st;
   logic [15:0] n_stall, n_flush;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FORWARDING(1), .DRAIN_CYCLES(3), .CNT_W(16)) u_fwd (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .mem_pcsrc(mem_pcsrc), .hold_req(hold_req),
      .pc_write(f_pcw), .ifid_write(f_ifw), .ifid_flush(f_iff),
      .idex_flush(f_idf), .exmem_flush(f_exf), .hold_ack(f_ack),
      .ctrl_state(f_st), .stall_cnt(f_stall), .flush_cnt(f_flush)
   );

   pipeline_hazard_ctrl #(.FORWARDING(0), .DRAIN_CYCLES(3), .CNT_W(16)) u_nofwd (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .mem_pcsrc(mem_pcsrc), .hold_req(hold_req),
      .pc_write(n_pcw), .ifid_write(n_ifw), .ifid_flush(n_iff),
      .idex_flush(n_idf), .exmem_flush(n_exf), .hold_ack(n_ack),
      .ctrl_state(n_st), .stall_cnt(n_stall), .flush_cnt(n_flush)
   );

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2;
      logic       u1, u2, exmr, exw;
      logic [4:0] exrd;
      logic       memw;
      logic [4:0] memrd;
      logic       wbw;
      logic [4:0] wbrd;
      logic       pcsrc;
      logic       e_fstall;
      logic       e_nstall;
      logic       e_flush;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input string nm, input int rs1, input int rs2, input int u1,
                               input int u2, input int exmr, input int exw, input int exrd,
                               input int memw, input int memrd, input int wbw, input int wbrd,
                               input int pcsrc, input int fs, input int ns, input int fl);
      vec_t v;
      v.name = nm;
      v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);  v.u1 = 1'(u1);  v.u2 = 1'(u2);
      v.exmr = 1'(exmr); v.exw = 1'(exw); v.exrd = 5'(exrd);
      v.memw = 1'(memw); v.memrd = 5'(memrd); v.wbw = 1'(wbw); v.wbrd = 5'(wbrd);
      v.pcsrc = 1'(pcsrc);
      v.e_fstall = 1'(fs); v.e_nstall = 1'(ns); v.e_flush = 1'(fl);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
      mem_regwrite = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;
      mem_pcsrc = 0; hold_req = 0;
   endtask

   task automatic load_use();
      ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
   endtask

   // Leaves the bench just after a falling edge with reset released and the DUTs in RUN.
   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic apply_vec(input vec_t v);
      do_reset();
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
      ex_memread = v.exmr; ex_regwrite = v.exw; ex_rd = v.exrd;
      mem_regwrite = v.memw; mem_rd = v.memrd; wb_regwrite = v.wbw; wb_rd = v.wbrd;
      mem_pcsrc = v.pcsrc;
      #1;
      check({v.name, ".f_pc_write"},    32'(f_pcw), 32'(!v.e_fstall));
      check({v.name, ".f_ifid_write"},  32'(f_ifw), 32'(!v.e_fstall));
      check({v.name, ".f_idex_flush"},  32'(f_idf), 32'(v.e_fstall | v.e_flush));
      check({v.name, ".f_ifid_flush"},  32'(f_iff), 32'(v.e_flush));
      check({v.name, ".f_exmem_flush"}, 32'(f_exf), 32'(v.e_flush));
      check({v.name, ".n_pc_write"},    32'(n_pcw), 32'(!v.e_nstall));
      check({v.name, ".n_idex_flush"},  32'(n_idf), 32'(v.e_nstall | v.e_flush));
      @(posedge clk);
      #1;
      check({v.name, ".f_state"},     32'(f_st),    32'(v.e_fstall));
      check({v.name, ".f_stall_cnt"}, 32'(f_stall), 32'(v.e_fstall));
      check({v.name, ".f_flush_cnt"}, 32'(f_flush), 32'(v.e_flush));
      check({v.name, ".n_state"},     32'(n_st),    32'(v.e_nstall));
      check({v.name, ".n_stall_cnt"}, 32'(n_stall), 32'(v.e_nstall));
   endtask

   initial begin
      //              name         rs1 rs2 u1 u2 exmr exw exrd memw memrd wbw wbrd pcs fs ns fl
      vecs[0]  = mk("load_use",     5,  0, 1, 0, 1,   1,  5,   0,   0,    0,  0,   0,  1, 1, 0);
      vecs[1]  = mk("load_x0",      0,  0, 1, 0, 1,   1,  0,   0,   0,    0,  0,   0,  0, 0, 0);
      vecs[2]  = mk("mem_rs2",      0,  7, 0, 1, 0,   0,  0,   1,   7,    0,  0,   0,  0, 1, 0);
      vecs[3]  = mk("mem_rs2_nouse",0,  7, 0, 0, 0,   0,  0,   1,   7,    0,  0,   0,  0, 0, 0);
      vecs[4]  = mk("wb_rs1",       9,  0, 1, 0, 0,   0,  0,   0,   0,    1,  9,   0,  0, 1, 0);
      vecs[5]  = mk("ex_alu_rs2",   0,  3, 0, 1, 0,   1,  3,   0,   0,    0,  0,   0,  0, 1, 0);
      vecs[6]  = mk("load_rs2",    12, 12, 0, 1, 1,   1, 12,   0,   0,    0,  0,   0,  1, 1, 0);
      vecs[7]  = mk("load_nouse",   5,  0, 0, 0, 1,   1,  5,   0,   0,    0,  0,   0,  0, 0, 0);
      vecs[8]  = mk("pcsrc_hz",     5,  0, 1, 0, 1,   1,  5,   0,   0,    0,  0,   1,  0, 0, 1);
      vecs[9]  = mk("mem_x0",       0,  0, 1, 0, 0,   0,  0,   1,   0,    0,  0,   0,  0, 0, 0);
      vecs[10] = mk("idle",         4,  6, 1, 1, 0,   0,  0,   0,   0,    0,  0,   0,  0, 0, 0);
      vecs[11] = mk("mem_rd_mism", 10, 11, 1, 1, 0,   0,  0,   1,  12,    1, 13,   0,  0, 0, 0);

      clear_inputs();
      #2;
      check("rst.pc_write",    32'(f_pcw),   32'd0);
      check("rst.ifid_write",  32'(f_ifw),   32'd0);
      check("rst.ifid_flush",  32'(f_iff),   32'd1);
      check("rst.idex_flush",  32'(f_idf),   32'd1);
      check("rst.exmem_flush", 32'(f_exf),   32'd1);
      check("rst.hold_ack",    32'(f_ack),   32'd0);
      check("rst.state",       32'(f_st),    32'd0);
      check("rst.stall_cnt",   32'(f_stall), 32'd0);
      check("rst.flush_cnt",   32'(f_flush), 32'd0);

      for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

      // Hold handshake: requested in cycle t, DRAIN t+1..t+3, HELD from t+4.
      do_reset();
      repeat (9) @(negedge clk);
      hold_req = 1;
      #1;
      check("hold.t_state",    32'(f_st),  32'd0);
      check("hold.t_pc_write", 32'(f_pcw), 32'd0);
      check("hold.t_idex",     32'(f_idf), 32'd1);
      check("hold.t_ack",      32'(f_ack), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); #1;
         check($sformatf("hold.drain%0d_state", k), 32'(f_st),  32'd2);
         check($sformatf("hold.drain%0d_ack", k),   32'(f_ack), 32'd0);
      end
      for (int k = 4; k <= 9; k++) begin
         @(negedge clk); #1;
         check($sformatf("hold.held%0d_state", k), 32'(f_st),  32'd3);
         check($sformatf("hold.held%0d_ack", k),   32'(f_ack), 32'd1);
         check($sformatf("hold.held%0d_pcw", k),   32'(f_pcw), 32'd0);
      end
      @(negedge clk);
      hold_req = 0;
      #1;
      check("hold.release_ack", 32'(f_ack), 32'd1);
      @(negedge clk); #1;
      check("hold.run_state", 32'(f_st),  32'd0);
      check("hold.run_ack",   32'(f_ack), 32'd0);
      check("hold.run_pcw",   32'(f_pcw), 32'd1);

      // Redirect during the second DRAIN cycle restarts the drain count.
      do_reset();
      hold_req = 1;
      @(negedge clk); #1;
      check("dpc.t1_state", 32'(f_st), 32'd2);
      @(negedge clk);
      mem_pcsrc = 1;
      #1;
      check("dpc.t2_state", 32'(f_st),  32'd2);
      check("dpc.t2_pcw",   32'(f_pcw), 32'd1);
      check("dpc.t2_ifw",   32'(f_ifw), 32'd1);
      check("dpc.t2_iff",   32'(f_iff), 32'd1);
      check("dpc.t2_idf",   32'(f_idf), 32'd1);
      check("dpc.t2_exf",   32'(f_exf), 32'd1);
      @(negedge clk);
      mem_pcsrc = 0;
      #1;
      check("dpc.t3_state", 32'(f_st),    32'd2);
      check("dpc.flush_cnt", 32'(f_flush), 32'd1);
      @(negedge clk); #1;
      check("dpc.t4_state", 32'(f_st), 32'd2);
      @(negedge clk); #1;
      check("dpc.t5_state", 32'(f_st),  32'd2);
      check("dpc.t5_ack",   32'(f_ack), 32'd0);
      @(negedge clk); #1;
      check("dpc.t6_state", 32'(f_st),  32'd3);
      check("dpc.t6_ack",   32'(f_ack), 32'd1);

      // Asynchronous reset in HELD, away from any clock edge.
      #3;
      rst = 0;
      #1;
      check("arst.ack",       32'(f_ack),   32'd0);
      check("arst.state",     32'(f_st),    32'd0);
      check("arst.flush_cnt", 32'(f_flush), 32'd0);
      check("arst.pcw",       32'(f_pcw),   32'd0);
      check("arst.exf",       32'(f_exf),   32'd1);

      // Branch beats hold beats hazard in RUN.
      do_reset();
      hold_req = 1; mem_pcsrc = 1;
      load_use();
      #1;
      check("prio.pcw", 32'(f_pcw), 32'd1);
      check("prio.iff", 32'(f_iff), 32'd1);
      @(posedge clk); #1;
      check("prio.state",     32'(f_st),    32'd0);
      check("prio.flush_cnt", 32'(f_flush), 32'd1);
      check("prio.stall_cnt", 32'(f_stall), 32'd0);

      // Hold withdrawn during DRAIN returns to RUN with default controls.
      do_reset();
      hold_req = 1;
      @(negedge clk);
      hold_req = 0;
      #1;
      check("abort.state", 32'(f_st),  32'd2);
      check("abort.pcw",   32'(f_pcw), 32'd1);
      check("abort.idf",   32'(f_idf), 32'd0);
      @(negedge clk); #1;
      check("abort.run", 32'(f_st), 32'd0);

      // Stall counter saturation.
      do_reset();
      load_use();
      repeat (65534) @(posedge clk);
      #1;
      check("sat.f_fffe", 32'(f_stall), 32'h0000fffe);
      check("sat.state",  32'(f_st),    32'd1);
      repeat (7) @(posedge clk);
      #1;
      check("sat.f_ffff", 32'(f_stall), 32'h0000ffff);
      check("sat.n_ffff", 32'(n_stall), 32'h0000ffff);
      check("sat.f_flush", 32'(f_flush), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
